// File: rtl/virtio_queue_event_tracker.sv
// Per-virtqueue saturating pending-event counters with a round-robin valid/ready
// offer port; each accepted offer carries a wrapping per-queue sequence index.
module virtio_queue_event_tracker #(
    parameter int unsigned NUM_QUEUES = 3,
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned IDX_W      = 16,
    localparam int unsigned QID_W     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                          clk,
    input  logic                          csr_rst,
    input  logic [NUM_QUEUES-1:0]         q_enable,
    input  logic [NUM_QUEUES-1:0]         evt_set,
    input  logic [NUM_QUEUES-1:0]         ovf_clr,
    output logic                          evt_valid,
    output logic [QID_W-1:0]              evt_qid,
    output logic [IDX_W-1:0]              evt_idx,
    input  logic                          evt_ready,
    output logic [NUM_QUEUES-1:0]         pending,
    output logic [NUM_QUEUES*CNT_W-1:0]   pending_cnt,
    output logic [NUM_QUEUES-1:0]         ovf_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, OFFER, BUBBLE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q [NUM_QUEUES];
    logic [CNT_W-1:0]        cnt_d [NUM_QUEUES];
    logic [IDX_W-1:0]        seq_q [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]   pending_q, ovf_q;
    logic [NUM_QUEUES-1:0]   eligible_c, acc_vec_c, set_sat_c;
    logic                    valid_q, valid_d;
    logic [QID_W-1:0]        qid_q, qid_d, rr_q, rr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [QID_W-1:0]        grant_qid_c, cand_c;
    logic                    grant_found_c;
    logic                    accept_c;

    assign accept_c = valid_q & evt_ready;

    // Per-queue counter next-state; disable flush beats everything, set+accept cancel out.
    always_comb begin
        eligible_c = '0;
        acc_vec_c  = '0;
        set_sat_c  = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            cnt_d[q]      = cnt_q[q];
            acc_vec_c[q]  = accept_c && (qid_q == QID_W'(q));
            eligible_c[q] = q_enable[q] && (cnt_q[q] != '0);
            if (!q_enable[q]) begin
                cnt_d[q] = '0;
            end else if (evt_set[q] && !acc_vec_c[q]) begin
                if (cnt_q[q] == CNT_MAX) begin
                    set_sat_c[q] = 1'b1;
                end else begin
                    cnt_d[q] = cnt_q[q] + CNT_W'(1);
                end
            end else if (acc_vec_c[q] && !evt_set[q] && (cnt_q[q] != '0)) begin
                cnt_d[q] = cnt_q[q] - CNT_W'(1);
            end
        end
    end

    // Round-robin search starting at rr_q over registered counters.
    always_comb begin
        grant_found_c = 1'b0;
        grant_qid_c   = '0;
        cand_c        = '0;
        for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            cand_c = QID_W'((32'(rr_q) + i) % NUM_QUEUES);
            if (!grant_found_c && eligible_c[cand_c]) begin
                grant_found_c = 1'b1;
                grant_qid_c   = cand_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (csr_rst) begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                cnt_q[q] <= '0;
                seq_q[q] <= '0;
            end
            pending_q <= '0;
            ovf_q     <= '0;
        end else begin
            for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
                cnt_q[q]     <= cnt_d[q];
                pending_q[q] <= (cnt_d[q] != '0);
                if (set_sat_c[q]) begin
                    ovf_q[q] <= 1'b1;
                end else if (ovf_clr[q]) begin
                    ovf_q[q] <= 1'b0;
                end
                if (acc_vec_c[q]) begin
                    seq_q[q] <= seq_q[q] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (csr_rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            qid_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            qid_q   <= qid_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    // Offer FSM: the bubble lets the decremented count settle before re-arbitration.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        qid_d   = qid_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (grant_found_c) begin
                    valid_d = 1'b1;
                    qid_d   = grant_qid_c;
                    idx_d   = seq_q[grant_qid_c];
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    rr_d    = (qid_q == QID_W'(NUM_QUEUES - 1)) ? '0 : qid_q + QID_W'(1);
                    state_d = BUBBLE;
                end
            end
            BUBBLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending_cnt = '0;
        for (int unsigned q = 0; q < NUM_QUEUES; q++) begin
            pending_cnt[q*CNT_W +: CNT_W] = cnt_q[q];
        end
    end

    assign evt_valid  = valid_q;
    assign evt_qid    = qid_q;
    assign evt_idx    = idx_q;
    assign pending    = pending_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_virtio_queue_event_tracker.sv
// Bench for virtio_queue_event_tracker: directed scenarios, a behavioural model
// checked every cycle, plus literal expectations that pin the model.
module tb_virtio_queue_event_tracker;

    localparam int NQ      = 3;
    localparam int CW      = 4;
    localparam int IW      = 10;
    localparam int QW      = 2;
    localparam int CMAX    = (1 << CW) - 1;
    localparam int IDX_MAX = (1 << IW) - 1;

    logic              clk;
    logic              csr_rst;
    logic [NQ-1:0]     q_enable;
    logic [NQ-1:0]     evt_set;
    logic [NQ-1:0]     ovf_clr;
    logic              evt_valid;
    logic [QW-1:0]     evt_qid;
    logic [IW-1:0]     evt_idx;
    logic              evt_ready;
    logic [NQ-1:0]     pending;
    logic [NQ*CW-1:0]  pending_cnt;
    logic [NQ-1:0]     ovf_sticky;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    virtio_queue_event_tracker #(.NUM_QUEUES(NQ), .CNT_W(CW), .IDX_W(IW)) dut (
        .clk         (clk),
        .csr_rst     (csr_rst),
        .q_enable    (q_enable),
        .evt_set     (evt_set),
        .ovf_clr     (ovf_clr),
        .evt_valid   (evt_valid),
        .evt_qid     (evt_qid),
        .evt_idx     (evt_idx),
        .evt_ready   (evt_ready),
        .pending     (pending),
        .pending_cnt (pending_cnt),
        .ovf_sticky  (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: counts, sequence numbers and the offer slot as plain integers.
    int        m_cnt [NQ];
    int        m_seq [NQ];
    logic [NQ-1:0] m_ovf;
    bit        m_valid;
    int        m_qid, m_idx, m_rr;
    bit        m_gap;

    wire m_acc = m_valid && evt_ready;

    function automatic int pick();
        for (int i = 0; i < NQ; i++) begin
            int c;
            c = (m_rr + i) % NQ;
            if (q_enable[c] && m_cnt[c] > 0) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (csr_rst) begin
            for (int q = 0; q < NQ; q++) begin
                m_cnt[q] <= 0;
                m_seq[q] <= 0;
            end
            m_ovf   <= '0;
            m_valid <= 1'b0;
            m_qid   <= 0;
            m_idx   <= 0;
            m_rr    <= 0;
            m_gap   <= 1'b0;
        end else begin
            for (int q = 0; q < NQ; q++) begin
                if (!q_enable[q])
                    m_cnt[q] <= 0;
                else if (evt_set[q] && !(m_acc && m_qid == q))
                    m_cnt[q] <= (m_cnt[q] < CMAX) ? m_cnt[q] + 1 : CMAX;
                else if (!evt_set[q] && m_acc && m_qid == q && m_cnt[q] > 0)
                    m_cnt[q] <= m_cnt[q] - 1;
                if (q_enable[q] && evt_set[q] && !(m_acc && m_qid == q) && m_cnt[q] == CMAX)
                    m_ovf[q] <= 1'b1;
                else if (ovf_clr[q])
                    m_ovf[q] <= 1'b0;
                if (m_acc && m_qid == q)
                    m_seq[q] <= (m_seq[q] + 1) % (1 << IW);
            end
            if (m_valid) begin
                if (evt_ready) begin
                    m_valid <= 1'b0;
                    m_rr    <= (m_qid + 1) % NQ;
                    m_gap   <= 1'b1;
                end
            end else if (m_gap) begin
                m_gap <= 1'b0;
            end else if (pick() >= 0) begin
                m_valid <= 1'b1;
                m_qid   <= pick();
                m_idx   <= m_seq[pick()];
            end
        end
    end

    function automatic logic [NQ*CW-1:0] m_pcnt();
        logic [NQ*CW-1:0] r;
        r = '0;
        for (int q = 0; q < NQ; q++) r[q*CW +: CW] = CW'(m_cnt[q]);
        return r;
    endfunction

    function automatic logic [NQ-1:0] m_pend();
        logic [NQ-1:0] r;
        for (int q = 0; q < NQ; q++) r[q] = (m_cnt[q] != 0);
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("m_valid", 64'(evt_valid), 64'(m_valid));
            check("m_qid", 64'(evt_qid), 64'(m_qid));
            check("m_idx", 64'(evt_idx), 64'(m_idx));
            check("m_pending_cnt", 64'(pending_cnt), 64'(m_pcnt()));
            check("m_pending", 64'(pending), 64'(m_pend()));
            check("m_ovf", 64'(ovf_sticky), 64'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        csr_rst = 1'b1;
        tick();
        tick();
        csr_rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!evt_valid && n < 50) begin
            tick();
            n++;
        end
        check(nm, 64'(evt_valid), 64'd1);
    endtask

    initial begin
        int n;
        csr_rst   = 1'b1;
        q_enable  = '1;
        evt_set   = '0;
        ovf_clr   = '0;
        evt_ready = 1'b1;
        do_reset();
        cmp_en = 1'b1;
        tick();
        check("rst_valid", 64'(evt_valid), 64'd0);
        check("rst_cnt", 64'(pending_cnt), 64'd0);

        // Single event on q1, then a second offer carrying the incremented index.
        evt_set = 3'b010;
        tick();
        evt_set = '0;
        check("t1_cnt", 64'(pending_cnt), 64'h010);
        check("t1_novalid_yet", 64'(evt_valid), 64'd0);
        tick();
        check("t1_valid", 64'(evt_valid), 64'd1);
        check("t1_qid", 64'(evt_qid), 64'd1);
        check("t1_idx", 64'(evt_idx), 64'd0);
        tick();
        check("t1_acc_valid", 64'(evt_valid), 64'd0);
        check("t1_acc_cnt", 64'(pending_cnt), 64'd0);
        evt_set = 3'b010;
        tick();
        evt_set = '0;
        wait_valid("t1_wait2");
        check("t1_idx2", 64'(evt_idx), 64'd1);
        tick();
        tick();

        // Round-robin order from a fresh reset, twice.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            evt_set = 3'b111;
            tick();
            evt_set = '0;
            for (int i = 0; i < NQ; i++) begin
                wait_valid("t2_wait");
                check("t2_order", 64'(evt_qid), 64'(i));
                tick();
            end
            tick();
        end

        // Saturation and sticky overflow on q2 with the consumer stalled.
        evt_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            evt_set = 3'b100;
            tick();
        end
        evt_set = '0;
        check("t3_sat", 64'(pending_cnt[11:8]), 64'd15);
        check("t3_ovf", 64'(ovf_sticky[2]), 64'd1);
        check("t3_qid", 64'(evt_qid), 64'd2);
        ovf_clr = 3'b100;
        tick();
        ovf_clr = '0;
        check("t3_ovf_clr", 64'(ovf_sticky[2]), 64'd0);
        evt_set = 3'b100;
        tick();
        check("t3_ovf_reset", 64'(ovf_sticky[2]), 64'd1);
        ovf_clr = 3'b100;
        tick();
        evt_set = '0;
        ovf_clr = '0;
        check("t3_set_beats_clr", 64'(ovf_sticky[2]), 64'd1);
        check("t3_sat_hold", 64'(pending_cnt[11:8]), 64'd15);
        q_enable  = 3'b011;
        evt_ready = 1'b1;
        tick();
        q_enable  = '1;
        evt_ready = 1'b0;
        ovf_clr   = 3'b100;
        tick();
        ovf_clr = '0;
        tick();

        // Stalled offer on q0 stays stable, survives a disable, accept still advances seq.
        evt_set = 3'b001;
        tick();
        evt_set = '0;
        wait_valid("t4_wait");
        check("t4_qid", 64'(evt_qid), 64'd0);
        check("t4_idx", 64'(evt_idx), 64'd2);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) q_enable = 3'b110;
            tick();
            check("t4_hold_valid", 64'(evt_valid), 64'd1);
            check("t4_hold_qid", 64'(evt_qid), 64'd0);
            check("t4_hold_idx", 64'(evt_idx), 64'd2);
        end
        check("t4_flushed", 64'(pending_cnt[3:0]), 64'd0);
        q_enable  = '1;
        evt_ready = 1'b1;
        tick();
        check("t4_acc_valid", 64'(evt_valid), 64'd0);
        check("t4_acc_cnt", 64'(pending_cnt[3:0]), 64'd0);
        tick();

        // Set and accept in the same cycle leave the count unchanged.
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            evt_set = 3'b010;
            tick();
        end
        evt_set = '0;
        wait_valid("t5_wait");
        check("t5_qid", 64'(evt_qid), 64'd1);
        check("t5_cnt3", 64'(pending_cnt[7:4]), 64'd3);
        evt_set   = 3'b010;
        evt_ready = 1'b1;
        tick();
        evt_set   = '0;
        evt_ready = 1'b0;
        check("t5_cnt_hold", 64'(pending_cnt[7:4]), 64'd3);
        q_enable = 3'b101;
        tick();
        tick();
        q_enable = '1;
        check("t5_flushed", 64'(pending_cnt), 64'd0);

        // Drive q0 sequence index to its maximum, then confirm wrap to zero.
        evt_set   = 3'b001;
        evt_ready = 1'b1;
        n = 0;
        while (!(evt_valid && evt_qid == 2'd0 && 32'(evt_idx) == IDX_MAX) && n < 5000) begin
            tick();
            n++;
        end
        check("t6_reach_max", 64'(evt_idx), 64'(IDX_MAX));
        tick();
        wait_valid("t6_wait");
        check("t6_wrap_qid", 64'(evt_qid), 64'd0);
        check("t6_wrap_idx", 64'(evt_idx), 64'd0);
        evt_ready = 1'b0;
        evt_set   = '0;
        csr_rst   = 1'b1;
        tick();
        csr_rst = 1'b0;
        check("t6_rst_valid", 64'(evt_valid), 64'd0);
        check("t6_rst_qid", 64'(evt_qid), 64'd0);
        check("t6_rst_idx", 64'(evt_idx), 64'd0);
        check("t6_rst_cnt", 64'(pending_cnt), 64'd0);
        check("t6_rst_pend", 64'(pending), 64'd0);
        check("t6_rst_ovf", 64'(ovf_sticky), 64'd0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/virtio_queue_event_tracker.md
Name: virtio_queue_event_tracker

Overview:
Synthesizable, parametrised tracker of per-virtqueue pending events between two pipeline stages of the virtio device datapath, e.g. notify→avail-fetch or avail→used-writeback. It generalises the single-bit, three-queue set/clear pending flags into NUM_QUEUES saturating pending counters. A round-robin arbiter presents one pending queue at a time to the consumer stage over a valid/ready handshake. Each handshake also carries a per-queue wrapping sequence index, the next_avail_idx equivalent.

Parameters:
NUM_QUEUES, 3, number of virtqueues tracked (1..32)
CNT_W, 4, pending-counter width; max count 2^CNT_W-1
IDX_W, 16, sequence-index width; wraps modulo 2^IDX_W

Ports:
clk  in  1  single clock
csr_rst  in  1  synchronous active-high reset
q_enable  in  NUM_QUEUES  per-queue enable from CSR; 0 flushes that queue
evt_set  in  NUM_QUEUES  producer event pulses, one per queue per cycle
ovf_clr  in  NUM_QUEUES  clears the matching sticky overflow bit
evt_valid  out  1  a pending queue is offered to the consumer
evt_qid  out  $clog2(NUM_QUEUES) (min 1)  offered queue id
evt_idx  out  IDX_W  sequence index of offered queue
evt_ready  in  1  consumer accepts the offer
pending  out  NUM_QUEUES  per-queue (count != 0)
pending_cnt  out  NUM_QUEUES*CNT_W  flattened counters, queue 0 in LSBs
ovf_sticky  out  NUM_QUEUES  set when evt_set arrives at a saturated counter

Behaviour:
- All state is synchronous to clk. csr_rst clears all state regardless of the cycle it arrives in, including mid-handshake. Reset values:
  - counters 0, seq indices 0, ovf_sticky 0
  - evt_valid 0, evt_qid 0, evt_idx 0
  - rr pointer points to queue 0 as highest priority
- Accept = evt_valid & evt_ready.
- Counter update per queue q, priority order:
  - !q_enable[q]: count←0; evt_set ignored.
  - evt_set[q] and accept for q: count unchanged.
  - evt_set[q] only: count+1; at max, count holds and ovf_sticky[q]←1.
  - accept for q only: count−1; at 0, count holds (no underflow).
- ovf_sticky[q]: set has priority over ovf_clr[q] in the same cycle.
- Seq index per queue increments by 1 on every accept for q, including accepts that find count==0. It wraps from 2^IDX_W−1 to 0. It is not cleared by q_enable=0, only by csr_rst.
- Arbiter is round-robin over eligible queues (count!=0 & q_enable). It starts at the rr pointer. It is evaluated from registered counters only.
- Output register, state IDLE/OFFER/BUBBLE:
  - IDLE: if any eligible, load evt_qid, evt_idx and evt_valid=1, go to OFFER.
  - OFFER: evt_valid, evt_qid and evt_idx are held stable until accept. The offer is never retracted, even if the queue becomes disabled.
  - On accept: evt_valid←0, rr pointer←evt_qid+1 (mod NUM_QUEUES), go to BUBBLE.
  - BUBBLE: exactly one cycle, then IDLE. This guarantees the decremented count is seen before re-arbitration.
- Latency:
  - evt_set sampled at edge k → pending_cnt/pending updated after edge k.
  - evt_valid is asserted after edge k+1 if the tracker was idle.
  - Back-to-back offers are separated by at least 2 idle cycles: BUBBLE then IDLE arbitration.
- pending_cnt, pending and ovf_sticky are registered outputs.

Test Plan:
- Reset, then one evt_set[1] pulse, evt_ready=1 → pending_cnt q1=1 one cycle later. Next cycle evt_valid=1, evt_qid=1, evt_idx=0. After accept q1 count=0 and the next offer for q1 carries evt_idx=1.
- evt_set[0], [1] and [2] in the same cycle, evt_ready=1 → offers in qid order 0,1,2, each followed by a bubble. Re-pulse all three → order 0,1,2 again.
- 17 evt_set[2] pulses with CNT_W=4 and the consumer stalled → count=15, ovf_sticky[2]=1. ovf_clr[2] in a cycle with no evt_set[2] → ovf_sticky[2]=0. ovf_clr[2] and evt_set[2] in the same cycle → ovf_sticky[2] stays 1.
- Stall evt_ready=0 for 10 cycles with q0 offered → evt_valid, evt_qid and evt_idx are stable all 10 cycles. Deassert q_enable[0] during the stall → count 0 and the offer is still held. Accept → count stays 0 and seq q0 increments.
- Keep q1 count at 3 while asserting evt_set[1] in the same cycle as its accept → count stays 3.
- Preload seq q0 to 0xFFFF via 65535 accepts, then accept once more → evt_idx for q0 wraps to 0x0000. Assert csr_rst during OFFER → all outputs 0 in the next cycle.
